// File: rtl/ram_cache_sa.sv
// Set-associative (1/2-way) write-through, write-allocate word cache between CPU and data RAM.
// Optional read hit/miss counters are enabled by defining RAM_CACHE_STATS_EN.
//
// state | meaning
// IDLE  | serving CPU requests; reads hit combinationally, writes pass straight to RAM
// WAIT  | read miss issued, counting down the RAM read latency
// FILL  | RAM data valid, install it into the victim way
module ram_cache_sa #(
    parameter int DATA_WIDTH         = 16,
    parameter int RAM_REGISTER_COUNT = 1024,
    parameter int CACHE_SETS         = 4,
    parameter int WAYS               = 2,
    parameter int RAM_READ_LATENCY   = 1,
    localparam int ADDR_W            = $clog2(RAM_REGISTER_COUNT),
    localparam int IDX_W             = $clog2(CACHE_SETS),
    localparam int TAG_W             = ADDR_W - IDX_W
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [DATA_WIDTH-1:0] cpu_in_m,
    input  logic [DATA_WIDTH-1:0] cpu_out_m,
    input  logic                  cpu_write_m,
    input  logic                  cpu_read_m,
    input  logic [ADDR_W-1:0]     cpu_data_addr,
    output logic                  cpu_stall,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] ram_in_m,
    output logic [DATA_WIDTH-1:0] ram_out_m,
    output logic                  ram_write_m,
    output logic                  ram_read_m,
    output logic [ADDR_W-1:0]     ram_data_addr
`ifdef RAM_CACHE_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    generate
        if (WAYS != 1 && WAYS != 2) begin : g_bad_ways
            $error("ram_cache_sa: WAYS must be 1 or 2");
        end
        if (CACHE_SETS < 2 || (CACHE_SETS & (CACHE_SETS - 1)) != 0) begin : g_bad_sets
            $error("ram_cache_sa: CACHE_SETS must be a power of 2 and at least 2");
        end
        if (RAM_READ_LATENCY < 1 || RAM_READ_LATENCY > 15) begin : g_bad_lat
            $error("ram_cache_sa: RAM_READ_LATENCY must be 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, WAIT, FILL} state_t;

    localparam logic [3:0] LAT_LOAD = 4'(RAM_READ_LATENCY - 1);

    state_t                  state_q;
    logic [CACHE_SETS-1:0]   valid_q [WAYS];
    logic [TAG_W-1:0]        tag_q   [WAYS][CACHE_SETS];
    logic [DATA_WIDTH-1:0]   data_q  [WAYS][CACHE_SETS];
    logic [CACHE_SETS-1:0]   lru_q;
    logic [ADDR_W-1:0]       miss_addr_q;
    logic [3:0]              cnt_q;
    logic                    flush_pend_q;

    logic [IDX_W-1:0]        cpu_idx, miss_idx;
    logic [TAG_W-1:0]        cpu_tag, miss_tag;
    logic [WAYS-1:0]         hit_vec, set_valid, fill_valid;
    logic                    hit, hit_way, cpu_victim, fill_victim, acc_way;
    logic                    idle_write, idle_rd_hit, idle_rd_miss;

    assign cpu_idx  = cpu_data_addr[IDX_W-1:0];
    assign cpu_tag  = cpu_data_addr[ADDR_W-1:IDX_W];
    assign miss_idx = miss_addr_q[IDX_W-1:0];
    assign miss_tag = miss_addr_q[ADDR_W-1:IDX_W];

    // Victim: lowest invalid way, otherwise the way the LRU bit points at.
    function automatic logic pick_victim(input logic [WAYS-1:0] vld, input logic lru);
        logic v;
        v = (WAYS == 2) ? lru : 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!vld[w]) v = 1'(w);
        end
        return v;
    endfunction

    // A same-cycle flush makes the indexed set look empty, so accesses miss and allocate way 0.
    always_comb begin
        hit_vec    = '0;
        set_valid  = '0;
        fill_valid = '0;
        hit_way    = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            set_valid[w]  = valid_q[w][cpu_idx] && !flush;
            hit_vec[w]    = set_valid[w] && (tag_q[w][cpu_idx] == cpu_tag);
            fill_valid[w] = valid_q[w][miss_idx];
        end
        for (int w = 0; w < WAYS; w++) begin
            if (hit_vec[w]) hit_way = 1'(w);
        end
        hit         = |hit_vec;
        cpu_victim  = pick_victim(set_valid, lru_q[cpu_idx]);
        fill_victim = pick_victim(fill_valid, lru_q[miss_idx]);
        acc_way     = hit ? hit_way : cpu_victim;
    end

    assign idle_write   = !reset && (state_q == IDLE) && cpu_write_m;
    assign idle_rd_hit  = !reset && (state_q == IDLE) && cpu_read_m && !cpu_write_m && hit;
    assign idle_rd_miss = !reset && (state_q == IDLE) && cpu_read_m && !cpu_write_m && !hit;

    always_comb begin
        cpu_in_m      = '0;
        cpu_stall     = 1'b0;
        ram_read_m    = 1'b0;
        ram_write_m   = 1'b0;
        ram_out_m     = cpu_out_m;
        ram_data_addr = cpu_data_addr;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    ram_write_m = cpu_write_m;
                    if (cpu_write_m) begin
                        if (cpu_read_m) cpu_in_m = cpu_out_m;
                    end else if (cpu_read_m) begin
                        if (hit) begin
                            cpu_in_m = data_q[hit_way][cpu_idx];
                        end else begin
                            cpu_stall  = 1'b1;
                            ram_read_m = 1'b1;
                        end
                    end
                end
                WAIT, FILL: begin
                    cpu_stall     = 1'b1;
                    ram_data_addr = miss_addr_q;
                end
                default: ;
            endcase
        end
    end

    // Line storage carries no reset; valid bits decide what is meaningful.
    always_ff @(posedge clk) begin
        if (idle_write) begin
            data_q[acc_way][cpu_idx] <= cpu_out_m;
            tag_q[acc_way][cpu_idx]  <= cpu_tag;
        end else if (!reset && state_q == FILL) begin
            data_q[fill_victim][miss_idx] <= ram_in_m;
            tag_q[fill_victim][miss_idx]  <= miss_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            lru_q        <= '0;
            miss_addr_q  <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    flush_pend_q <= 1'b0;
                    if (flush) begin
                        for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
                    end
                    if (cpu_write_m) begin
                        valid_q[acc_way][cpu_idx] <= 1'b1;
                        lru_q[cpu_idx]            <= ~acc_way;
                    end else if (cpu_read_m) begin
                        if (hit) begin
                            lru_q[cpu_idx] <= ~hit_way;
                        end else begin
                            miss_addr_q <= cpu_data_addr;
                            cnt_q       <= LAT_LOAD;
                            state_q     <= (LAT_LOAD == 4'd0) ? FILL : WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (flush) flush_pend_q <= 1'b1;
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_q <= FILL;
                end
                FILL: begin
                    // A flush seen during the miss wipes the set state, including the new line.
                    if (flush || flush_pend_q) begin
                        for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
                    end else begin
                        valid_q[fill_victim][miss_idx] <= 1'b1;
                        lru_q[miss_idx]                <= ~fill_victim;
                    end
                    flush_pend_q <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef RAM_CACHE_STATS_EN
    logic retry_q;

    // The IDLE cycle right after a fill is the stalled request retrying, not a new request.
    always_ff @(posedge clk) begin
        if (reset) begin
            retry_q    <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            retry_q <= (state_q == FILL);
            if (idle_rd_hit && !retry_q && hit_count != '1) hit_count <= hit_count + 32'd1;
            if (idle_rd_miss && !retry_q && miss_count != '1) miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: doc/ram_cache_sa.md
Name: ram_cache_sa

Overview:
- Parametrised successor to the CPU/RAM pass-through cache; sits between the CPU data port and data RAM.
- Set-associative (1- or 2-way), write-through, write-allocate word cache.
- Supports a configurable multi-cycle RAM read latency.
- Stalls the CPU only on read misses; provides a single-cycle flush.

Parameters:
- DATA_WIDTH, 16, data word width.
- RAM_REGISTER_COUNT, 1024, RAM depth in words; ADDR_W = $clog2(RAM_REGISTER_COUNT).
- CACHE_SETS, 4, number of sets; power of 2, ≥2; IDX_W = $clog2(CACHE_SETS), TAG_W = ADDR_W-IDX_W.
- WAYS, 2, associativity; legal values 1 or 2 (elaboration error otherwise).
- RAM_READ_LATENCY, 1, cycles from ram_read_m asserted to ram_in_m valid; range 1..15.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_in_m  out  DATA_WIDTH  read data to CPU.
- cpu_out_m  in  DATA_WIDTH  write data from CPU.
- cpu_write_m  in  1  CPU write request.
- cpu_read_m  in  1  CPU read request.
- cpu_data_addr  in  ADDR_W  CPU word address.
- cpu_stall  out  1  CPU must hold its request stable while high.
- flush  in  1  invalidate all lines.
- ram_in_m  in  DATA_WIDTH  RAM read data.
- ram_out_m  out  DATA_WIDTH  RAM write data.
- ram_write_m  out  1  RAM write strobe.
- ram_read_m  out  1  RAM read strobe, one-cycle pulse.
- ram_data_addr  out  ADDR_W  RAM address.

Behaviour:
- Address split: index = addr[IDX_W-1:0], tag = addr[ADDR_W-1:IDX_W]. Hit = valid && tag match in any way of the indexed set.
- Reset (synchronous, reset=1): all valid bits 0; LRU bits 0; FSM to IDLE.
- Output values during reset:
  - cpu_stall=0, ram_read_m=0, ram_write_m=0.
  - ram_data_addr=cpu_data_addr, ram_out_m=cpu_out_m, cpu_in_m=0.
- FSM states: IDLE, WAIT, FILL.
- IDLE, read hit:
  - cpu_in_m = hit way data, combinationally, same cycle.
  - cpu_stall=0.
  - LRU[set] updated to point at the other way (WAYS=2).
- IDLE, read miss:
  - cpu_stall=1 combinationally.
  - ram_read_m=1 for exactly one cycle.
  - Miss address is latched; go to WAIT with counter = RAM_READ_LATENCY-1.
- WAIT: cpu_stall=1; counter decrements; at 0 go to FILL.
- FILL:
  - Capture ram_in_m into the victim way: the first invalid way, else the LRU way (way 0 when WAYS=1).
  - Set valid and tag; update LRU; go to IDLE.
  - cpu_stall stays 1 in FILL. The next IDLE cycle hits, with no stall.
  - Miss penalty = RAM_READ_LATENCY+1 stall cycles.
- Write (IDLE only):
  - ram_write_m=cpu_write_m, same cycle; no stall (write-through).
  - Hit: update the hit way. Miss: allocate the victim way (write-allocate).
  - Update LRU in both cases.
- Read and write asserted together: treated as a write. cpu_in_m = cpu_out_m (forward); no stall.
- During WAIT/FILL:
  - ram_write_m forced 0; CPU requests ignored.
  - ram_data_addr = latched miss address.
- flush=1:
  - In IDLE: all valid bits cleared at the clock edge.
  - Any access in the same cycle is treated as a miss (reads stall; writes still go through and allocate after the clear).
  - During WAIT/FILL: the flush is registered as pending. The in-flight fill completes, then valid is cleared on entry to IDLE; the following read misses again.
- Reset during WAIT/FILL:
  - FSM returns to IDLE; no line is installed.
  - ram_read_m never re-pulses for the aborted miss.
- Tags are compared at full TAG_W; no aliasing.

Optional Feature:
- Macro RAM_CACHE_STATS_EN.
- Defined:
  - Adds outputs hit_count and miss_count, each 32 bits.
  - Counts CPU read hits and read misses, one count per request; a stalled retry hit is not counted.
  - Counters saturate at all-ones and clear on reset. flush does not clear them.
- Undefined: ports and counters absent; functional behaviour identical.

Test Plan:
- Reset, then read addr 0x005 with RAM_READ_LATENCY=3, ram returns 0x1234 -> ram_read_m one pulse; cpu_stall high 4 cycles; then cpu_in_m=0x1234, stall 0.
- Write 0x00A=0xBEEF, then read 0x00A next cycle -> ram_write_m=1 with ram_out_m=0xBEEF; read hits, no stall, cpu_in_m=0xBEEF.
- WAYS=2, CACHE_SETS=4: write 0x001, 0x005, read 0x001, write 0x009 -> 0x005 evicted (LRU); reads of 0x001 and 0x009 hit, read of 0x005 misses.
- flush asserted during WAIT of a miss to 0x020 -> fill completes and stall drops; next read of 0x020 misses again.
- Simultaneous read+write to 0x030 with data 0x0F0F -> cpu_in_m=0x0F0F same cycle, no stall, ram_write_m=1.
- With RAM_CACHE_STATS_EN: 3 hits + 2 misses -> hit_count=3, miss_count=2; reset -> both 0.
